// File: rtl/unfunnel_pkg.sv
// Shared constants and config decode for the 128->512 beat packer.
package unfunnel_pkg;

  localparam int W_NARROW      = 128;
  localparam int LANES         = 4;
  localparam int CFG_BEATS_LSB = 0;
  localparam int CFG_BEATS_W   = 2;

  typedef enum logic [CFG_BEATS_W-1:0] {
    BEATS_4    = 2'd0,
    BEATS_2    = 2'd1,
    BEATS_1    = 2'd2,
    BEATS_RSVD = 2'd3
  } beats_e;

  // Reserved code 3 falls into the default and packs a full 4-beat word.
  function automatic logic [2:0] beats_from_cfg(input logic [CFG_BEATS_W-1:0] code);
    case (beats_e'(code))
      BEATS_2: beats_from_cfg = 3'd2;
      BEATS_1: beats_from_cfg = 3'd1;
      default: beats_from_cfg = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/unfunnel_dat_4_1_dat_out_reg.sv
// Valid/ready output holding register: loads a word, holds it until the consumer takes it.
module dat_out_reg #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_dat;
  logic             r_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_dat   <= i_dat;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dat   = r_dat;
  assign o_valid = r_valid;

endmodule

// File: rtl/unfunnel_dat_4_1.sv
// Packs 128-bit narrow beats into 512-bit words, 1/2/4 beats per word chosen per word.
// Optional UNFUNNEL_LAST_EN adds i_0_last to close a word early.
module unfunnel_dat_4_1 #(
  parameter int W     = unfunnel_pkg::W_NARROW,
  parameter int LANES = unfunnel_pkg::LANES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [W-1:0]       i_0_dat,
  input  logic               i_0_valid,
  output logic               i_0_ready,
`ifdef UNFUNNEL_LAST_EN
  input  logic               i_0_last,
`endif
  input  logic [7:0]         t_cfg_dat,
  output logic [W*LANES-1:0] t_0_dat,
  output logic               t_0_valid,
  input  logic               t_0_ready,
  output logic [7:0]         mode
);
  import unfunnel_pkg::*;

  localparam int CW = $clog2(LANES);

  logic [CW-1:0]      r_cnt;
  logic [CW:0]        r_n;
  logic [7:0]         r_mode;
  logic [W*LANES-1:0] r_acc;

  logic               w_first;
  logic [CW:0]        w_n;
  logic               w_last;
  logic               w_accept;
  logic [W*LANES-1:0] w_word;

  // The first beat of a word decodes the live config; later beats use the latched count.
  assign w_first = (r_cnt == '0);
  assign w_n     = w_first
                 ? (CW+1)'(beats_from_cfg(t_cfg_dat[CFG_BEATS_LSB +: CFG_BEATS_W]))
                 : r_n;

`ifdef UNFUNNEL_LAST_EN
  assign w_last = ({1'b0, r_cnt} == w_n - 1'b1) || i_0_last;
`else
  assign w_last = ({1'b0, r_cnt} == w_n - 1'b1);
`endif

  // Only a closing beat can be stalled, and only by an undrained output word.
  assign i_0_ready = !w_last || !t_0_valid || t_0_ready;
  assign w_accept  = i_0_valid && i_0_ready;

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_word = w_first ? '0 : r_acc;
    w_word[r_cnt*W +: W] = i_0_dat;
  end

  // NOTE: the accumulator is a plain register (not RAM), so it is cleared on reset like the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_n    <= (CW+1)'(LANES);
      r_mode <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_acc <= w_word;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_mode <= t_cfg_dat;
        r_n    <= w_n;
      end
    end
  end

  dat_out_reg #(.WIDTH(W*LANES)) u_dat_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_accept && w_last),
    .i_dat   (w_word),
    .i_ready (t_0_ready),
    .o_dat   (t_0_dat),
    .o_valid (t_0_valid)
  );

  assign mode = r_mode;

endmodule

// File: tb/tb_unfunnel_dat_4_1.sv
// Randomized bench for unfunnel_dat_4_1 against a queue-based word-packing model.
// Define UNFUNNEL_LAST_EN to also exercise early word close.
module tb_unfunnel_dat_4_1;

  localparam int W  = 128;
  localparam int WW = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  i_0_dat;
  logic          i_0_valid;
  logic          i_0_ready;
  logic          i_0_last;
  logic [7:0]    t_cfg_dat;
  logic [WW-1:0] t_0_dat;
  logic          t_0_valid;
  logic          t_0_ready;
  logic [7:0]    mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unfunnel_dat_4_1 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_0_dat   (i_0_dat),
    .i_0_valid (i_0_valid),
    .i_0_ready (i_0_ready),
`ifdef UNFUNNEL_LAST_EN
    .i_0_last  (i_0_last),
`endif
    .t_cfg_dat (t_cfg_dat),
    .t_0_dat   (t_0_dat),
    .t_0_valid (t_0_valid),
    .t_0_ready (t_0_ready),
    .mode      (mode)
  );

  // Reference model: beats of the open word, its beat target and mode, and the output slot.
  logic [W-1:0]  m_q[$];
  int            m_n;
  logic [7:0]    m_mode;
  logic          m_valid;
  logic [WW-1:0] m_dat;
  int            m_words;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int cfg_to_n(input logic [7:0] cfg);
    if (cfg[1:0] == 2'd1) return 2;
    if (cfg[1:0] == 2'd2) return 1;
    return 4;
  endfunction

  function automatic bit m_closing();
    int  n;
    bit  early;
    n = (m_q.size() == 0) ? cfg_to_n(t_cfg_dat) : m_n;
`ifdef UNFUNNEL_LAST_EN
    early = i_0_last;
`else
    early = 1'b0;
`endif
    return (m_q.size() + 1 >= n) || early;
  endfunction

  function automatic bit m_ready();
    return !m_closing() || !m_valid || t_0_ready;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_n     = 4;
    m_mode  = '0;
    m_valid = 1'b0;
    m_dat   = '0;
  endtask

  task automatic model_step();
    bit            acc;
    bit            close;
    logic [WW-1:0] word;
    acc   = i_0_valid && m_ready();
    close = m_closing();
    if (m_valid && t_0_ready) m_valid = 1'b0;
    if (acc) begin
      if (m_q.size() == 0) begin
        m_n    = cfg_to_n(t_cfg_dat);
        m_mode = t_cfg_dat;
      end
      m_q.push_back(i_0_dat);
      if (close) begin
        word = '0;
        foreach (m_q[k]) word[k*W +: W] = m_q[k];
        m_dat   = word;
        m_valid = 1'b1;
        m_words++;
        m_q.delete();
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_i_0_ready"}, WW'(i_0_ready), WW'(m_ready()));
    check({ph, "_t_0_valid"}, WW'(t_0_valid), WW'(m_valid));
    check({ph, "_t_0_dat"},   t_0_dat,        m_dat);
    check({ph, "_mode"},      WW'(mode),      WW'(m_mode));
  endtask

  initial begin
    int   valid_pct;
    int   rdy_pct;
    int   last_pct;
    logic [7:0] ph_cfg;

    reset_n   = 1'b0;
    i_0_dat   = '0;
    i_0_valid = 1'b0;
    i_0_last  = 1'b0;
    t_cfg_dat = '0;
    t_0_ready = 1'b0;
    m_words   = 0;
    model_reset();
    valid_pct = 100;
    rdy_pct   = 100;
    last_pct  = 0;
    ph_cfg    = '0;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    compare_all("reset");

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      if ((cyc % 256) == 0) begin
        // Phase 0 of each group of four runs at full rate to exercise bubble-free streaming.
        valid_pct = ((cyc / 256) % 4 == 0) ? 100 : int'($urandom_range(30, 100));
        rdy_pct   = ((cyc / 256) % 4 == 0) ? 100 : int'($urandom_range(10, 100));
        last_pct  = int'($urandom_range(0, 25));
        ph_cfg    = 8'($urandom);
      end
      if (cyc == 1500 || cyc == 3001 || cyc == 4502) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      i_0_dat   = {$urandom, $urandom, $urandom, $urandom};
      i_0_valid = ($urandom_range(1, 100) <= valid_pct);
      t_0_ready = ($urandom_range(1, 100) <= rdy_pct);
      i_0_last  = ($urandom_range(1, 100) <= last_pct);
      t_cfg_dat = ($urandom_range(0, 9) < 7) ? ph_cfg : 8'($urandom);
      @(negedge clk);
      compare_all(reset_n ? "run" : "midrst");
    end

    check("words_seen", WW'(m_words > 100), WW'(1));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
